// File: rtl/tenant_demux_if.sv
// Boundary bundle for tenant_demux: one ingress AXI4-Stream and Q flattened egress lanes.
// Lane i of every m_axis_* bus occupies [i*W +: W].
interface tenant_demux_if #(
  parameter int D = 256,
  parameter int U = 128,
  parameter int Q = 8
);
  localparam int K = D / 8;

  logic [D-1:0]   s_axis_tdata;
  logic [K-1:0]   s_axis_tkeep;
  logic [U-1:0]   s_axis_tuser;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic           s_axis_tlast;

  logic [Q*D-1:0] m_axis_tdata;
  logic [Q*K-1:0] m_axis_tkeep;
  logic [Q*U-1:0] m_axis_tuser;
  logic [Q-1:0]   m_axis_tvalid;
  logic [Q-1:0]   m_axis_tready;
  logic [Q-1:0]   m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser,
    input  s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tuser,
    output m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser,
    output s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tuser,
    input  m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/tenant_demux.sv
// Per-tenant AXI4-Stream demux: FIFO-buffered ingress steered by tuser user ID.
// Define TENANT_DEMUX_STATS_EN to add per-lane packet and drop counters.
module tenant_demux #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 8,
  parameter int USER_ID_LSB          = 64,
  parameter int USER_ID_WIDTH        = 8,
  parameter int FIFO_DEPTH_BITS      = 4
) (
  input logic axis_aclk,
  input logic axis_resetn,
  tenant_demux_if.slave bus
`ifdef TENANT_DEMUX_STATS_EN
  ,
  output logic [NUM_QUEUES*32-1:0] stat_pkt_cnt,
  output logic [31:0]              stat_drop_cnt
`endif
);
  localparam int D     = C_S_AXIS_DATA_WIDTH;
  localparam int K     = D / 8;
  localparam int U     = C_S_AXIS_TUSER_WIDTH;
  localparam int Q     = NUM_QUEUES;
  localparam int AW    = FIFO_DEPTH_BITS;
  localparam int DEPTH = 2 ** AW;
  localparam int QW    = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [AW:0] NF = (AW+1)'(DEPTH - 1);

  typedef struct packed {
    logic [D-1:0] data;
    logic [K-1:0] keep;
    logic [U-1:0] user;
    logic         last;
  } beat_t;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  beat_t         mem_q [DEPTH];
  beat_t         head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [QW-1:0] dest_q, dest_d;
  logic          push, pop, empty, id_ok;
  logic [USER_ID_WIDTH-1:0] id;
  logic [QW-1:0] id_lane;

  assign empty = (cnt_q == '0);
  assign bus.s_axis_tready = (cnt_q < NF);
  assign push = bus.s_axis_tvalid & bus.s_axis_tready;

  assign head    = mem_q[rd_ptr_q];
  assign id      = head.user[USER_ID_LSB +: USER_ID_WIDTH];
  assign id_ok   = (32'(id) < Q);
  assign id_lane = id[QW-1:0];

  // Payload fans out to every lane; only tvalid selects the tenant.
  assign bus.m_axis_tdata = {Q{head.data}};
  assign bus.m_axis_tkeep = {Q{head.keep}};
  assign bus.m_axis_tuser = {Q{head.user}};
  assign bus.m_axis_tlast = {Q{head.last}};

  always_ff @(posedge axis_aclk) begin
    if (push) mem_q[wr_ptr_q] <= '{
      data: bus.s_axis_tdata,
      keep: bus.s_axis_tkeep,
      user: bus.s_axis_tuser,
      last: bus.s_axis_tlast
    };
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // The SOP decision and the first beat's transfer share one cycle.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    pop     = 1'b0;
    bus.m_axis_tvalid = '0;
    unique case (state_q)
      IDLE: if (!empty) begin
        if (id_ok) begin
          dest_d = id_lane;
          bus.m_axis_tvalid[id_lane] = 1'b1;
          pop = bus.m_axis_tready[id_lane];
          if (pop && !head.last) state_d = FWD;
        end else begin
          pop = 1'b1;
          if (!head.last) state_d = DROP;
        end
      end
      FWD: if (!empty) begin
        bus.m_axis_tvalid[dest_q] = 1'b1;
        pop = bus.m_axis_tready[dest_q];
        if (pop && head.last) state_d = IDLE;
      end
      DROP: if (!empty) begin
        pop = 1'b1;
        if (head.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      dest_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      dest_q   <= dest_d;
    end
  end

`ifdef TENANT_DEMUX_STATS_EN
  logic [Q-1:0][31:0] pkt_q, pkt_d;
  logic [31:0]        drop_q, drop_d;
  logic               is_drop;

  assign is_drop = (state_q == DROP) || (state_q == IDLE && !id_ok);

  always_comb begin
    pkt_d  = pkt_q;
    drop_d = drop_q;
    if (pop && head.last) begin
      if (is_drop) drop_d = drop_q + 32'd1;
      else if (state_q == FWD) pkt_d[dest_q] = pkt_q[dest_q] + 32'd1;
      else pkt_d[id_lane] = pkt_q[id_lane] + 32'd1;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      drop_q <= drop_d;
    end
  end

  assign stat_pkt_cnt  = pkt_q;
  assign stat_drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_tenant_demux.sv
// Bench for tenant_demux: directed timing checks, a packet table and random
// traffic against a packet-level scoreboard.
module tb_tenant_demux;
  localparam int D = 256;
  localparam int K = D / 8;
  localparam int U = 128;
  localparam int Q = 8;

  typedef struct packed {
    logic [D-1:0] data;
    logic [K-1:0] keep;
    logic [U-1:0] user;
    logic         last;
  } beat_t;

  typedef struct {
    int    lane;
    beat_t b;
  } exp_t;

  typedef struct {
    int id;
    int len;
    int exp_lane;
    int exp_beats;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tenant_demux_if #(.D(D), .U(U), .Q(Q)) bus ();

`ifdef TENANT_DEMUX_STATS_EN
  logic [Q*32-1:0] stat_pkt_cnt;
  logic [31:0]     stat_drop_cnt;
`endif

  tenant_demux dut (
    .axis_aclk   (clk),
    .axis_resetn (rst_n),
    .bus         (bus)
`ifdef TENANT_DEMUX_STATS_EN
    ,
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_drop_cnt (stat_drop_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  int   lane_beats[Q];
  int   mpkt[Q];
  int   mdrop;
  bit   sop;
  int   cur_id;
  bit   rnd_rdy;

  bit    stall;
  int    stall_lane;
  beat_t stall_beat;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic beat_t lane_beat(input int l);
    beat_t b;
    b.data = bus.m_axis_tdata[l*D +: D];
    b.keep = bus.m_axis_tkeep[l*K +: K];
    b.user = bus.m_axis_tuser[l*U +: U];
    b.last = bus.m_axis_tlast[l];
    return b;
  endfunction

  function automatic beat_t make_beat(input int id, input bit last);
    beat_t b;
    b.data = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
    b.keep = $urandom();
    b.user = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.user[64 +: 8] = 8'(id);
    b.last = last;
    return b;
  endfunction

  // Reference: the packet's tenant comes from its first beat; only IDs below Q are delivered.
  task automatic model_accept(input beat_t b);
    exp_t e;
    if (sop) cur_id = int'(b.user[64 +: 8]);
    if (cur_id < Q) begin
      e.lane = cur_id;
      e.b = b;
      exp_q.push_back(e);
    end
    if (b.last) begin
      if (cur_id < Q) mpkt[cur_id]++;
      else mdrop++;
    end
    sop = b.last;
  endtask

  task automatic model_reset();
    exp_q.delete();
    sop = 1'b1;
    cur_id = 0;
    mdrop = 0;
    for (int l = 0; l < Q; l++) mpkt[l] = 0;
  endtask

  task automatic drive(input beat_t b);
    bus.s_axis_tdata = b.data;
    bus.s_axis_tkeep = b.keep;
    bus.s_axis_tuser = b.user;
    bus.s_axis_tlast = b.last;
  endtask

  task automatic push_beat(input beat_t b);
    bit ok;
    int n;
    n = 0;
    drive(b);
    bus.s_axis_tvalid = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.s_axis_tready;
      @(posedge clk);
      #1;
      if (rnd_rdy) bus.m_axis_tready = 8'($urandom());
      n++;
    end while (!ok && n < 100);
    bus.s_axis_tvalid = 1'b0;
    if (ok) model_accept(b);
    else check("push_timeout", 0, 1);
  endtask

  task automatic push_pkt(input int id, input int len);
    for (int k = 0; k < len; k++) push_beat(make_beat(id, k == len - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.m_axis_tready = 8'($urandom());
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    bus.s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      logic [Q-1:0] vld;
      beat_t b;
      exp_t e;
      vld = bus.m_axis_tvalid;
      if (vld != '0) check("onehot_tvalid", $countones(vld), 1);
      if (stall) begin
        n_cmp++;
        if (!vld[stall_lane] || lane_beat(stall_lane) != stall_beat) begin
          n_bad++;
          $display("FAIL stall_stable: lane %0d valid %b data %h want data %h",
                   stall_lane, vld[stall_lane],
                   lane_beat(stall_lane).data[31:0], stall_beat.data[31:0]);
        end
      end
      stall = 1'b0;
      for (int l = 0; l < Q; l++) begin
        if (vld[l]) begin
          b = lane_beat(l);
          if (bus.m_axis_tready[l]) begin
            lane_beats[l]++;
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_bad++;
              $display("FAIL unexpected_beat: lane %0d data %h, none expected", l, b.data[31:0]);
            end else begin
              e = exp_q.pop_front();
              if (e.lane != l || e.b != b) begin
                n_bad++;
                $display("FAIL scoreboard: lane %0d data %h keep %h last %b want lane %0d data %h keep %h last %b",
                         l, b.data[31:0], b.keep, b.last,
                         e.lane, e.b.data[31:0], e.b.keep, e.b.last);
              end
            end
          end else begin
            stall = 1'b1;
            stall_lane = l;
            stall_beat = b;
          end
        end
      end
    end
  end

  vec_t tbl[8];
  int   snap[Q];

  initial begin
    int got_lane, got_n, acc, stall_at;
    beat_t b;

    tbl[0] = '{2,   3, 2,  3};
    tbl[1] = '{0,   1, 0,  1};
    tbl[2] = '{7,   1, 7,  1};
    tbl[3] = '{9,   4, -1, 0};
    tbl[4] = '{255, 2, -1, 0};
    tbl[5] = '{5,   5, 5,  5};
    tbl[6] = '{8,   1, -1, 0};
    tbl[7] = '{1,   2, 1,  2};

    for (int l = 0; l < Q; l++) lane_beats[l] = 0;
    rnd_rdy = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    bus.s_axis_tkeep = '0;
    bus.s_axis_tuser = '0;
    bus.s_axis_tlast = 1'b0;
    bus.m_axis_tready = '1;
    model_reset();
    #1;
    check("rst_tvalid_during", bus.m_axis_tvalid, 0);
    do_reset();
    check("rst_tvalid", bus.m_axis_tvalid, 0);
    check("rst_s_tready", bus.s_axis_tready, 1);

    // 3-beat packet to lane 2, valid the cycle after each accept
    for (int k = 0; k < 3; k++) begin
      push_beat(make_beat(2, k == 2));
      check("t1_lane2_valid", bus.m_axis_tvalid, 8'h04);
    end
    tick();
    check("t1_idle_after", bus.m_axis_tvalid, 0);

    // back-to-back single-beat packets, no bubble
    push_beat(make_beat(0, 1'b1));
    check("t2_lane0", bus.m_axis_tvalid, 8'h01);
    push_beat(make_beat(7, 1'b1));
    check("t2_lane7", bus.m_axis_tvalid, 8'h80);
    tick();
    check("t2_idle_after", bus.m_axis_tvalid, 0);

    // 4-beat packet to id 9 is dropped and drained on the fly
    for (int k = 0; k < 4; k++) begin
      push_beat(make_beat(9, k == 3));
      check("t3_drop_quiet", bus.m_axis_tvalid, 0);
    end
    push_beat(make_beat(4, 1'b1));
    check("t3_next_lane4", bus.m_axis_tvalid, 8'h10);
    wait_drain();
`ifdef TENANT_DEMUX_STATS_EN
    tick();
    check("t3_drop_cnt", stat_drop_cnt, 1);
`endif

    // 20-beat packet with lane 3 stalled: ingress stops at 15 buffered beats
    bus.m_axis_tready = 8'hF7;
    acc = 0;
    stall_at = -1;
    b = make_beat(3, 1'b0);
    for (int c = 0; c < 80 && acc < 20; c++) begin
      if (c == 25) bus.m_axis_tready = '1;
      drive(b);
      bus.s_axis_tvalid = 1'b1;
      @(negedge clk);
      if (!bus.s_axis_tready && stall_at < 0) stall_at = acc;
      if (bus.s_axis_tready) begin
        @(posedge clk);
        #1;
        model_accept(b);
        acc++;
        b = make_beat(3, acc == 19);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    bus.s_axis_tvalid = 1'b0;
    check("t4_stall_at", stall_at, 15);
    check("t4_accepted", acc, 20);
    wait_drain();
    tick();
    check("t4_idle_after", bus.m_axis_tvalid, 0);

    // reset in the middle of a packet
    push_beat(make_beat(2, 1'b0));
    push_beat(make_beat(2, 1'b0));
    drive(make_beat(2, 1'b0));
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_rst_tvalid", bus.m_axis_tvalid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_beat(make_beat(1, 1'b1));
    check("t5_lane1", bus.m_axis_tvalid, 8'h02);
    wait_drain();

    // packet table
    for (int v = 0; v < 8; v++) begin
      for (int l = 0; l < Q; l++) snap[l] = lane_beats[l];
      push_pkt(tbl[v].id, tbl[v].len);
      wait_drain();
      repeat (tbl[v].len + 2) tick();
      got_lane = -1;
      got_n = 0;
      for (int l = 0; l < Q; l++) begin
        if (lane_beats[l] != snap[l]) begin
          got_lane = l;
          got_n += lane_beats[l] - snap[l];
        end
      end
      check($sformatf("tbl%0d_lane", v), got_lane, tbl[v].exp_lane);
      check($sformatf("tbl%0d_beats", v), got_n, tbl[v].exp_beats);
    end

    // random traffic, random per-cycle egress ready
    rnd_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      push_pkt($urandom_range(0, 11), $urandom_range(1, 5));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_rdy = 1'b0;
    bus.m_axis_tready = '1;
    wait_drain();
    repeat (20) tick();
    check("rand_exp_empty", exp_q.size(), 0);
`ifdef TENANT_DEMUX_STATS_EN
    for (int l = 0; l < Q; l++)
      check($sformatf("rand_pkt_cnt%0d", l), stat_pkt_cnt[l*32 +: 32], mpkt[l]);
    check("rand_drop_cnt", stat_drop_cnt, mdrop);

    // 3 packets to tenant 1 and 2 to tenant 5 after a fresh reset
    do_reset();
    for (int p = 0; p < 3; p++) push_pkt(1, 2);
    for (int p = 0; p < 2; p++) push_pkt(5, 1);
    wait_drain();
    repeat (3) tick();
    for (int l = 0; l < Q; l++)
      check($sformatf("t6_pkt_cnt%0d", l), stat_pkt_cnt[l*32 +: 32],
            (l == 1) ? 3 : (l == 5) ? 2 : 0);
    check("t6_drop_cnt", stat_drop_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
